// File: rtl/hci_wide_lane_splitter_if.sv
// Bundle of the wide HCI initiator port and the N_LANES narrow TCDM ports around the splitter.
// The splitter takes the slave view; the initiator/memory side environment takes the master view.
interface hci_wide_lane_splitter_if #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned NDW     = 32,
  parameter int unsigned AW      = 32
) ();
  logic                       w_req;
  logic                       w_gnt;
  logic [AW-1:0]              w_add;
  logic                       w_wen;
  logic [N_LANES*NDW-1:0]     w_data;
  logic [N_LANES*NDW/8-1:0]   w_be;
  logic [N_LANES*NDW-1:0]     w_r_data;
  logic                       w_r_valid;
  logic                       w_r_ready;

  logic [N_LANES-1:0]         n_req;
  logic [N_LANES-1:0]         n_gnt;
  logic [N_LANES*AW-1:0]      n_add;
  logic [N_LANES-1:0]         n_wen;
  logic [N_LANES*NDW-1:0]     n_data;
  logic [N_LANES*NDW/8-1:0]   n_be;
  logic [N_LANES*NDW-1:0]     n_r_data;
  logic [N_LANES-1:0]         n_r_valid;
  logic [N_LANES-1:0]         n_r_ready;

  modport master (
    output w_req, w_add, w_wen, w_data, w_be, w_r_ready,
    output n_gnt, n_r_data, n_r_valid,
    input  w_gnt, w_r_data, w_r_valid,
    input  n_req, n_add, n_wen, n_data, n_be, n_r_ready
  );

  modport slave (
    input  w_req, w_add, w_wen, w_data, w_be, w_r_ready,
    input  n_gnt, n_r_data, n_r_valid,
    output w_gnt, w_r_data, w_r_valid,
    output n_req, n_add, n_wen, n_data, n_be, n_r_ready
  );
endinterface

// File: rtl/hci_wide_lane_splitter.sv
// Splits one wide HCI initiator port into N_LANES narrow TCDM ports with per-lane grant
// tracking, an outstanding-transaction credit limit and per-lane response reassembly FIFOs.
module hci_wide_lane_splitter #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned NDW     = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned DEPTH   = 2
) (
  input logic                     clk_i,
  input logic                     rst_i,
  input logic                     clear_i,
  hci_wide_lane_splitter_if.slave bus
);
  localparam int unsigned WORD_BYTES = NDW / 8;
  localparam int unsigned CW         = $clog2(DEPTH + 1);
  localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PARTIAL = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [N_LANES-1:0]         lane_done_q, lane_done_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N_LANES-1:0][PW-1:0] wptr_q, wptr_d;
  logic [N_LANES-1:0][PW-1:0] rptr_q, rptr_d;
  logic [N_LANES-1:0][CW-1:0] fcnt_q, fcnt_d;
  logic [NDW-1:0]             mem_q [N_LANES][DEPTH];
  logic [NDW-1:0]             mem_d [N_LANES][DEPTH];

  logic                       credit_ok_s;
  logic                       w_gnt_s;
  logic                       w_r_valid_s;
  logic                       pop_s;
  logic [N_LANES-1:0]         n_req_s;
  logic [N_LANES-1:0]         accepted_s;
  logic [N_LANES-1:0]         full_s;
  logic [N_LANES-1:0]         nonempty_s;
  logic [N_LANES-1:0]         push_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = ptr + PW'(1'b1);
    end
  endfunction

  // Lane requests are withheld entirely while the credit limit is reached
  always_comb begin
    credit_ok_s = (cnt_q < CNT_MAX);
    n_req_s     = {N_LANES{bus.w_req & credit_ok_s}} & ~lane_done_q;
    accepted_s  = n_req_s & bus.n_gnt;
    w_gnt_s     = bus.w_req & credit_ok_s & (&(lane_done_q | bus.n_gnt));
  end

  // Lane address offsets wrap modulo 2^AW; response data is the FIFO heads side by side
  always_comb begin
    bus.n_add    = {(N_LANES*AW){1'b0}};
    bus.w_r_data = {(N_LANES*NDW){1'b0}};
    for (int f = 0; f < N_LANES; f++) begin
      bus.n_add[f*AW +: AW]     = bus.w_add + AW'(f * WORD_BYTES);
      bus.w_r_data[f*NDW +: NDW] = mem_q[f][rptr_q[f]];
    end
  end

  // Grant tracking: remember lanes already granted so they are not re-issued
  always_comb begin
    state_d     = state_q;
    lane_done_d = lane_done_q;
    case (state_q)
      IDLE: begin
        if (w_gnt_s) begin
          state_d     = IDLE;
          lane_done_d = {N_LANES{1'b0}};
        end else if (|accepted_s) begin
          state_d     = PARTIAL;
          lane_done_d = accepted_s;
        end else begin
          state_d     = IDLE;
          lane_done_d = lane_done_q;
        end
      end
      PARTIAL: begin
        if (w_gnt_s) begin
          state_d     = IDLE;
          lane_done_d = {N_LANES{1'b0}};
        end else begin
          state_d     = PARTIAL;
          lane_done_d = lane_done_q | accepted_s;
        end
      end
      default: begin
        state_d     = IDLE;
        lane_done_d = {N_LANES{1'b0}};
      end
    endcase
  end

  // Outstanding wide transactions: grant adds, wide pop retires
  always_comb begin
    case ({w_gnt_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1'b1);
      2'b01:   cnt_d = cnt_q - CW'(1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Per-lane response FIFOs; all lanes pop together when the wide response is taken
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    mem_d  = mem_q;
    for (int f = 0; f < N_LANES; f++) begin
      full_s[f]     = (fcnt_q[f] == CNT_MAX);
      nonempty_s[f] = (fcnt_q[f] != {CW{1'b0}});
      push_s[f]     = bus.n_r_valid[f] & ~full_s[f];
    end
    w_r_valid_s = &nonempty_s;
    pop_s       = w_r_valid_s & bus.w_r_ready;
    for (int f = 0; f < N_LANES; f++) begin
      if (push_s[f]) begin
        mem_d[f][wptr_q[f]] = bus.n_r_data[f*NDW +: NDW];
        wptr_d[f]           = ptr_inc(wptr_q[f]);
      end else begin
        wptr_d[f] = wptr_q[f];
      end
      if (pop_s) begin
        rptr_d[f] = ptr_inc(rptr_q[f]);
      end else begin
        rptr_d[f] = rptr_q[f];
      end
      case ({push_s[f], pop_s})
        2'b10:   fcnt_d[f] = fcnt_q[f] + CW'(1'b1);
        2'b01:   fcnt_d[f] = fcnt_q[f] - CW'(1'b1);
        default: fcnt_d[f] = fcnt_q[f];
      endcase
    end
  end

  assign bus.n_req     = n_req_s;
  assign bus.n_wen     = {N_LANES{bus.w_wen}};
  assign bus.n_data    = bus.w_data;
  assign bus.n_be      = bus.w_be;
  assign bus.n_r_ready = ~full_s;
  assign bus.w_gnt     = w_gnt_s;
  assign bus.w_r_valid = w_r_valid_s;

  // State registers; clear_i discards everything exactly like reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lane_done_q <= {N_LANES{1'b0}};
      cnt_q       <= {CW{1'b0}};
      wptr_q      <= {(N_LANES*PW){1'b0}};
      rptr_q      <= {(N_LANES*PW){1'b0}};
      fcnt_q      <= {(N_LANES*CW){1'b0}};
      mem_q       <= '{default: {NDW{1'b0}}};
    end else if (clear_i) begin
      state_q     <= IDLE;
      lane_done_q <= {N_LANES{1'b0}};
      cnt_q       <= {CW{1'b0}};
      wptr_q      <= {(N_LANES*PW){1'b0}};
      rptr_q      <= {(N_LANES*PW){1'b0}};
      fcnt_q      <= {(N_LANES*CW){1'b0}};
      mem_q       <= '{default: {NDW{1'b0}}};
    end else begin
      state_q     <= state_d;
      lane_done_q <= lane_done_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
      mem_q       <= mem_d;
    end
  end

  // Initiator protocol and credit invariants
  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    (lane_done_q != {N_LANES{1'b0}}) |-> bus.w_req);
  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    cnt_q <= CNT_MAX);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    !((cnt_q == {CW{1'b0}}) && pop_s && !w_gnt_s));
  a_no_overrun: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    (bus.n_r_valid & full_s) == {N_LANES{1'b0}});

endmodule
